pixel_writeback_ctrl: RTL

Sequences the AXI4 write-back of one decoded frame of packed pixel words. It takes the 32-bit word stream from the pixel packer and splits each output line into INCR bursts of up to BURST_MAX beats. It issues AW, W and B independently with a bounded number of bursts in flight, and flushes the packer at frame start. It sits between the pixel packer and the AXI write master port of the JPEG decoder.

---
 rtl/pixel_wb_pkg.sv | 22 ++
 rtl/pixel_writeback_ctrl_if.sv | 43 ++++
 rtl/pixel_wb_burst_gen.sv | 57 +++++
 rtl/pixel_writeback_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_wb_pkg.sv
// Shared types, AXI constants and burst sizing helper for the
// pixel write-back controller.
package pixel_wb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [7:0] burst_beats(
        input logic [31:0] rem,
        input logic [7:0]  bmax
    );
        return (rem >= {24'd0, bmax}) ? bmax : rem[7:0];
    endfunction

endpackage

// File: rtl/pixel_writeback_ctrl_if.sv
// Packed-word stream plus AXI4 AW/W/B channels of the write-back path.
// master = controller side, slave = packer/interconnect side.
interface pixel_writeback_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_valid_i;
    logic              data_ready_o;
    logic [31:0]       data_i;

    logic              awvalid_o;
    logic              awready_i;
    logic [ADDR_W-1:0] awaddr_o;
    logic [7:0]        awlen_o;
    logic [2:0]        awsize_o;
    logic [1:0]        awburst_o;

    logic              wvalid_o;
    logic              wready_i;
    logic [31:0]       wdata_o;
    logic [3:0]        wstrb_o;
    logic              wlast_o;

    logic              bvalid_i;
    logic              bready_o;
    logic [1:0]        bresp_i;

    modport master (
        input  data_valid_i, data_i, awready_i, wready_i,
        input  bvalid_i, bresp_i,
        output data_ready_o, awvalid_o, awaddr_o, awlen_o,
        output awsize_o, awburst_o, wvalid_o, wdata_o,
        output wstrb_o, wlast_o, bready_o
    );

    modport slave (
        output data_valid_i, data_i, awready_i, wready_i,
        output bvalid_i, bresp_i,
        input  data_ready_o, awvalid_o, awaddr_o, awlen_o,
        input  awsize_o, awburst_o, wvalid_o, wdata_o,
        input  wstrb_o, wlast_o, bready_o
    );

endinterface

// File: rtl/pixel_wb_burst_gen.sv
// Line/burst walker: splits each line into BURST_MAX-beat bursts with
// the remainder last; advances one burst per adv_i.
module pixel_wb_burst_gen
    import pixel_wb_pkg::*;
#(
    parameter int LEN_W     = 12,
    parameter int BURST_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LEN_W-1:0] line_words_i,
    input  logic [LEN_W-1:0] line_cnt_i,
    input  logic             adv_i,
    output logic [7:0]       beats_o,
    output logic             last_of_line_o,
    output logic             last_of_frame_o
);

    logic [LEN_W-1:0] words_cfg_q, words_cfg_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [LEN_W-1:0] lines_left_q, lines_left_d;

    always_comb begin
        beats_o         = burst_beats(32'(words_left_q), 8'(BURST_MAX));
        last_of_line_o  = words_left_q <= LEN_W'(BURST_MAX);
        last_of_frame_o = last_of_line_o && (lines_left_q == LEN_W'(1));
        words_cfg_d     = words_cfg_q;
        words_left_d    = words_left_q;
        lines_left_d    = lines_left_q;
        if (load_i) begin
            words_cfg_d  = line_words_i;
            words_left_d = line_words_i;
            lines_left_d = line_cnt_i;
        end else if (adv_i) begin
            if (last_of_line_o) begin
                words_left_d = words_cfg_q;
                lines_left_d = lines_left_q - LEN_W'(1);
            end else begin
                words_left_d = words_left_q - LEN_W'(BURST_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_cfg_q  <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
        end else begin
            words_cfg_q  <= words_cfg_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
        end
    end

endmodule

// File: rtl/pixel_writeback_ctrl.sv
// AXI4 write-back sequencer for one frame of packed pixel words:
// independent AW/W/B with bounded bursts in flight and W lead.
module pixel_writeback_ctrl
    import pixel_wb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 12,
    parameter int BURST_MAX       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      base_addr_i,
    input  logic [ADDR_W-1:0]      stride_i,
    input  logic [LEN_W-1:0]       line_words_i,
    input  logic [LEN_W-1:0]       line_cnt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   flush_o,
    pixel_writeback_ctrl_if.master bus
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CMP_W = LEN_W + 1;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              err_q, err_d, flush_q, flush_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [7:0]        beat_q, beat_d;

    logic [7:0] aw_beats, w_beats;
    logic       aw_lol, aw_lof, w_lol, w_lof;
    logic       start_acc, zero_cfg, run, aw_valid, w_en, w_last;
    logic       aw_hs, w_hs, b_hs;

    pixel_wb_burst_gen #(.LEN_W(LEN_W), .BURST_MAX(BURST_MAX)) u_aw_gen (
        .clk, .rst_n, .load_i(start_acc), .line_words_i, .line_cnt_i,
        .adv_i(aw_hs), .beats_o(aw_beats),
        .last_of_line_o(aw_lol), .last_of_frame_o(aw_lof)
    );

    pixel_wb_burst_gen #(.LEN_W(LEN_W), .BURST_MAX(BURST_MAX)) u_w_gen (
        .clk, .rst_n, .load_i(start_acc), .line_words_i, .line_cnt_i,
        .adv_i(w_hs && w_last), .beats_o(w_beats),
        .last_of_line_o(w_lol), .last_of_frame_o(w_lof)
    );

    // W may run ahead of AW by at most MAX_OUTSTANDING completed bursts
    always_comb begin
        start_acc = start_i && (state_q == ST_IDLE) && !busy_q;
        zero_cfg  = (line_words_i == '0) || (line_cnt_i == '0);
        run       = state_q == ST_RUN;
        aw_valid  = run && !aw_done_q &&
                    (outst_q < OUT_W'(MAX_OUTSTANDING));
        w_en      = run && !w_done_q &&
                    ({1'b0, w_cnt_q} <
                     ({1'b0, aw_cnt_q} + CMP_W'(MAX_OUTSTANDING)));
        w_last    = beat_q == (w_beats - 8'd1);
        aw_hs     = aw_valid && bus.awready_i;
        w_hs      = w_en && bus.data_valid_i && bus.wready_i;
        b_hs      = (state_q != ST_IDLE) && bus.bvalid_i;
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        flush_d     = 1'b0;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        line_base_d = line_base_q;
        aw_addr_d   = aw_addr_q;
        stride_d    = stride_q;
        aw_cnt_d    = aw_cnt_q;
        w_cnt_d     = w_cnt_q;
        beat_d      = beat_q;
        outst_d     = outst_q + OUT_W'(aw_hs) - OUT_W'(b_hs);
        if (start_acc) begin
            busy_d      = 1'b1;
            flush_d     = 1'b1;
            err_d       = 1'b0;
            aw_done_d   = zero_cfg;
            w_done_d    = zero_cfg;
            line_base_d = base_addr_i;
            aw_addr_d   = base_addr_i;
            stride_d    = stride_i;
            aw_cnt_d    = '0;
            w_cnt_d     = '0;
            beat_d      = '0;
        end else if (done_q) begin
            busy_d = 1'b0;
        end
        if (aw_hs) begin
            aw_cnt_d = aw_cnt_q + LEN_W'(1);
            if (aw_lof) aw_done_d = 1'b1;
            if (aw_lol) begin
                line_base_d = line_base_q + stride_q;
                aw_addr_d   = line_base_q + stride_q;
            end else begin
                aw_addr_d = aw_addr_q + ADDR_W'(BURST_MAX * 4);
            end
        end
        if (w_hs) begin
            if (w_last) begin
                beat_d  = '0;
                w_cnt_d = w_cnt_q + LEN_W'(1);
                if (w_lol && w_lof) w_done_d = 1'b1;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
        if (b_hs && (bus.bresp_i != RESP_OKAY)) err_d = 1'b1;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = zero_cfg ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (aw_done_q && w_done_q) state_d = ST_DRAIN;
            ST_DRAIN: if (outst_q == '0) begin
                          state_d = ST_IDLE;
                          done_d  = 1'b1;
                      end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flush_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            line_base_q <= '0;
            aw_addr_q   <= '0;
            stride_q    <= '0;
            aw_cnt_q    <= '0;
            w_cnt_q     <= '0;
            outst_q     <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            flush_q     <= flush_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            line_base_q <= line_base_d;
            aw_addr_q   <= aw_addr_d;
            stride_q    <= stride_d;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
            outst_q     <= outst_d;
            beat_q      <= beat_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign flush_o = flush_q;

    assign bus.awvalid_o    = aw_valid;
    assign bus.awaddr_o     = aw_addr_q;
    assign bus.awlen_o      = aw_beats - 8'd1;
    assign bus.awsize_o     = SIZE_4B;
    assign bus.awburst_o    = BURST_INCR;
    assign bus.wvalid_o     = bus.data_valid_i && w_en;
    assign bus.data_ready_o = bus.wready_i && w_en;
    assign bus.wdata_o      = bus.data_i;
    assign bus.wstrb_o      = 4'hF;
    assign bus.wlast_o      = w_last;
    assign bus.bready_o     = state_q != ST_IDLE;

endmodule
